// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory and decode handshake bundle for instr_fetch
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC-driving fetch stage with request FSM and fetch buffer
// INSTR_FETCH_BYPASS_EN: present an empty-buffer response to decode in the same cycle
module instr_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pc_cur,
  output logic [31:0]   pc_next,
  output logic          pc_en,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_target,
  instr_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t          state;
  logic            req_q;
  logic [31:0]     req_pc;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_after;
  logic [63:0]     buf_mem [DEPTH];
  logic [63:0]     head;
  logic            count_nz;
  logic            push;
  logic            pop;
  logic            space;
  logic            space_after;
  logic            granted;
  logic [31:0]     tgt_pc;
  logic            unused_tgt_bits;

  assign tgt_pc          = {redirect_target[31:2], 2'b00};
  assign unused_tgt_bits = ^redirect_target[1:0];
  assign granted         = (state == REQ) && bus.imem_gnt;
  assign head            = buf_mem[rd_ptr];
  assign count_nz        = (count != '0);

  // A flush wins over any push or pop in the same cycle.
  assign pop         = count_nz && bus.id_ready && !redirect_valid;
  assign count_after = count + CW'(push) - CW'(pop);
  assign space       = (count + CW'(state == WAIT)) < DEPTH_C;
  assign space_after = count_after < DEPTH_C;

`ifdef INSTR_FETCH_BYPASS_EN
  logic bypass;
  assign bypass       = !count_nz && (state == WAIT) && bus.imem_rvalid && !redirect_valid;
  assign push         = (state == WAIT) && bus.imem_rvalid && !redirect_valid && !(bypass && bus.id_ready);
  assign bus.if_valid = count_nz || bypass;
  assign bus.if_instr = count_nz ? head[31:0]  : (bypass ? bus.imem_rdata : 32'h0);
  assign bus.if_pc    = count_nz ? head[63:32] : (bypass ? req_pc : 32'h0);
`else
  assign push         = (state == WAIT) && bus.imem_rvalid && !redirect_valid;
  assign bus.if_valid = count_nz;
  assign bus.if_instr = count_nz ? head[31:0]  : 32'h0;
  assign bus.if_pc    = count_nz ? head[63:32] : 32'h0;
`endif

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_cur;

  always_comb begin
    pc_next = pc_cur;
    if (rst)
      pc_next = RESET_PC;
    else if (redirect_valid)
      pc_next = tgt_pc;
    else if (granted)
      pc_next = pc_cur + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      req_pc <= RESET_PC;
      pc_en  <= 1'b0;
    end else begin
      pc_en <= 1'b1;
      if (redirect_valid) begin
        // A request already accepted by memory must have its response drained.
        case (state)
          IDLE: begin
            state <= REQ;
            req_q <= 1'b1;
          end
          REQ: begin
            if (bus.imem_gnt) begin
              state <= DROP;
              req_q <= 1'b0;
            end
          end
          WAIT: begin
            if (bus.imem_rvalid) begin
              state <= REQ;
              req_q <= 1'b1;
            end else begin
              state <= DROP;
              req_q <= 1'b0;
            end
          end
          DROP: begin
            if (bus.imem_rvalid) begin
              state <= REQ;
              req_q <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        endcase
      end else begin
        case (state)
          IDLE: begin
            if (space) begin
              state <= REQ;
              req_q <= 1'b1;
            end
          end
          REQ: begin
            if (bus.imem_gnt) begin
              req_pc <= pc_cur;
              state  <= WAIT;
              req_q  <= 1'b0;
            end
          end
          WAIT: begin
            if (bus.imem_rvalid) begin
              if (space_after) begin
                state <= REQ;
                req_q <= 1'b1;
              end else begin
                state <= IDLE;
                req_q <= 1'b0;
              end
            end
          end
          DROP: begin
            if (bus.imem_rvalid) begin
              state <= REQ;
              req_q <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= {req_pc, bus.imem_rdata};
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_after;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch: vector table, corner sequences, random traffic
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_cur          (pc_cur),
    .pc_next         (pc_next),
    .pc_en           (pc_en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .bus             (bus)
  );

  // PC register: clears while disabled, otherwise follows pc_next.
  always_ff @(posedge clk) pc_cur <= pc_en ? pc_next : 32'h0;

  int checks = 0;
  int errors = 0;

  logic        s_rst, s_rdy, s_redir, s_gnt, s_rv;
  logic [31:0] s_tgt, s_rd;
  bit          auto_mem;
  int          gnt_pct, max_dly;

  logic [31:0] exp_pc, exp_fetch, pend_addr;
  int          ndeliv, pend_dly;
  bit          pend, prev_redir;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] pnext;
    logic        en;
  } vec_t;
  vec_t tbl [10];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: apply stimulus after the edge, settle, then score this cycle.
  task automatic cycle();
    @(posedge clk);
    #1;
    rst             = s_rst;
    bus.id_ready    = s_rdy;
    redirect_valid  = s_redir;
    redirect_target = s_tgt;
    if (auto_mem) begin
      bus.imem_gnt    = bus.imem_req && ($urandom_range(99) < gnt_pct);
      bus.imem_rvalid = pend && (pend_dly == 0);
      bus.imem_rdata  = bus.imem_rvalid ? memf(pend_addr) : $urandom;
    end else begin
      bus.imem_gnt    = s_gnt;
      bus.imem_rvalid = s_rv;
      bus.imem_rdata  = s_rd;
    end
    #3;
    if (s_rst) begin
      exp_pc     = 32'h0;
      exp_fetch  = 32'h0;
      pend       = 1'b0;
      prev_redir = 1'b0;
    end else begin
      if (prev_redir)
        chk("valid_after_redirect", {31'h0, bus.if_valid}, 32'h0);
      if (auto_mem && pend)
        chk("single_outstanding", {31'h0, bus.imem_req}, 32'h0);
      if (bus.imem_req && bus.imem_gnt && !s_redir) begin
        chk("fetch_addr", bus.imem_addr, exp_fetch);
        exp_fetch += 32'd4;
      end
      if (bus.if_valid && s_rdy && !s_redir) begin
        chk("deliver_pc", bus.if_pc, exp_pc);
        chk("deliver_instr", bus.if_instr, memf(exp_pc));
        exp_pc += 32'd4;
        ndeliv++;
      end
      if (s_redir) begin
        exp_pc    = {s_tgt[31:2], 2'b00};
        exp_fetch = exp_pc;
      end
      prev_redir = s_redir;
      if (auto_mem) begin
        if (bus.imem_rvalid)
          pend = 1'b0;
        else if (pend && pend_dly > 0)
          pend_dly--;
        if (bus.imem_req && bus.imem_gnt) begin
          pend      = 1'b1;
          pend_addr = bus.imem_addr;
          pend_dly  = int'($urandom_range(max_dly));
        end
      end
    end
  endtask

  task automatic do_reset();
    s_rst = 1'b1; s_redir = 1'b0; s_gnt = 1'b0; s_rv = 1'b0; s_rd = 32'h0;
    cycle();
    cycle();
    chk("rst_pc_en", {31'h0, pc_en}, 32'h0);
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_imem_req", {31'h0, bus.imem_req}, 32'h0);
    chk("rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    s_rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; bus.id_ready = 1'b0;
    s_rdy = 1'b1; s_tgt = 32'h0; auto_mem = 1'b0; gnt_pct = 100; max_dly = 0;
    ndeliv = 0; pend = 1'b0; pend_dly = 0; pend_addr = 32'h0; prev_redir = 1'b0;

    // gnt rv rd rdy | req addr vld if_pc pc_next pc_en
    tbl[0] = '{1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'h00, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h04, 1'b1};
    tbl[2] = '{1'b0, 1'b1, memf(32'h0), 1'b1, 1'b0, 32'h04, 1'b0, 32'h0, 32'h04, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h04, 1'b1, 32'h0, 32'h08, 1'b1};
    tbl[4] = '{1'b0, 1'b1, memf(32'h4), 1'b1, 1'b0, 32'h08, 1'b0, 32'h0, 32'h08, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h08, 1'b1, 32'h4, 32'h0C, 1'b1};
    tbl[6] = '{1'b0, 1'b1, memf(32'h8), 1'b1, 1'b0, 32'h0C, 1'b0, 32'h0, 32'h0C, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h0C, 1'b1, 32'h8, 32'h10, 1'b1};
    tbl[8] = '{1'b0, 1'b1, memf(32'hC), 1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 32'h10, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h10, 1'b1, 32'hC, 32'h10, 1'b1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      s_gnt = tbl[i].gnt; s_rv = tbl[i].rv; s_rd = tbl[i].rd; s_rdy = tbl[i].rdy;
      cycle();
      chk($sformatf("t%0d_req", i), {31'h0, bus.imem_req}, {31'h0, tbl[i].req});
      chk($sformatf("t%0d_addr", i), bus.imem_addr, tbl[i].addr);
      chk($sformatf("t%0d_valid", i), {31'h0, bus.if_valid}, {31'h0, tbl[i].vld});
      chk($sformatf("t%0d_pc_next", i), pc_next, tbl[i].pnext);
      chk($sformatf("t%0d_pc_en", i), {31'h0, pc_en}, {31'h0, tbl[i].en});
      if (tbl[i].vld) begin
        chk($sformatf("t%0d_if_pc", i), bus.if_pc, tbl[i].ipc);
        chk($sformatf("t%0d_if_instr", i), bus.if_instr, memf(tbl[i].ipc));
      end
    end

    // Back-pressure: buffer fills, fetch stops at 8, then drains in order.
    auto_mem = 1'b1; gnt_pct = 100; max_dly = 0;
    do_reset();
    s_rdy = 1'b0;
    repeat (12) cycle();
    s_rdy = 1'b1;
    cycle();
    chk("stall_valid", {31'h0, bus.if_valid}, 32'h1);
    chk("stall_head_pc", bus.if_pc, 32'h0);
    chk("stall_req_low", {31'h0, bus.imem_req}, 32'h0);
    chk("stall_pc_cur", pc_cur, 32'h8);
    chk("stall_pc_next", pc_next, 32'h8);
    cycle();
    chk("stall_second_pc", bus.if_pc, 32'h4);
    chk("stall_second_valid", {31'h0, bus.if_valid}, 32'h1);
    s_rdy = 1'b0;
    cycle();
    chk("stall_two_only", {31'h0, bus.if_valid}, 32'h0);
    chk("stall_resume_req", {31'h0, bus.imem_req}, 32'h1);
    chk("stall_resume_addr", bus.imem_addr, 32'h8);
    s_rdy = 1'b1;
    repeat (8) cycle();

    // Redirect while waiting: stale 0xDEADBEEF must be dropped.
    auto_mem = 1'b0;
    do_reset();
    s_rdy = 1'b1;
    cycle();
    s_gnt = 1'b1; cycle();
    chk("rd_req0", {31'h0, bus.imem_req}, 32'h1);
    s_gnt = 1'b0; s_redir = 1'b1; s_tgt = 32'h100; cycle();
    chk("rd_pc_next", pc_next, 32'h100);
    s_redir = 1'b0; s_rv = 1'b1; s_rd = 32'hDEAD_BEEF; cycle();
    chk("rd_pc_cur", pc_cur, 32'h100);
    chk("rd_drop_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("rd_drop_req", {31'h0, bus.imem_req}, 32'h0);
    s_rv = 1'b0; s_gnt = 1'b1; cycle();
    chk("rd_after_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("rd_after_addr", bus.imem_addr, 32'h100);
    s_gnt = 1'b0; s_rv = 1'b1; s_rd = memf(32'h100); cycle();
    s_rv = 1'b0; s_rdy = 1'b0; cycle();
    chk("rd_new_pc", bus.if_pc, 32'h100);
    chk("rd_new_instr", bus.if_instr, memf(32'h100));

    // Redirect to 0x203 together with rvalid and pop.
    s_gnt = 1'b1; cycle();
    s_gnt = 1'b0; s_rv = 1'b1; s_rd = memf(32'h104); s_rdy = 1'b1; s_redir = 1'b1; s_tgt = 32'h203;
    cycle();
    chk("rp_pc_next", pc_next, 32'h200);
    s_rv = 1'b0; s_redir = 1'b0; cycle();
    chk("rp_empty", {31'h0, bus.if_valid}, 32'h0);
    chk("rp_addr", bus.imem_addr, 32'h200);
    chk("rp_req", {31'h0, bus.imem_req}, 32'h1);
    s_gnt = 1'b1; cycle();
    s_gnt = 1'b0; s_rv = 1'b1; s_rd = memf(32'h200); cycle();
    s_rv = 1'b0; cycle();
    chk("rp_if_pc", bus.if_pc, 32'h200);

    // Reset while waiting; a late response must not be buffered.
    s_gnt = 1'b1; cycle();
    s_gnt = 1'b0; s_rst = 1'b1; cycle();
    cycle();
    s_rst = 1'b0; cycle();
    cycle();
    chk("rw_req", {31'h0, bus.imem_req}, 32'h1);
    chk("rw_addr", bus.imem_addr, 32'h0);
    s_rv = 1'b1; s_rd = 32'hBAD0_BAD0; cycle();
    s_rv = 1'b0; s_gnt = 1'b1; cycle();
    chk("rw_no_push", {31'h0, bus.if_valid}, 32'h0);
    chk("rw_addr2", bus.imem_addr, 32'h0);
    s_gnt = 1'b0; s_rv = 1'b1; s_rd = memf(32'h0); cycle();
    s_rv = 1'b0; cycle();
    chk("rw_if_pc", bus.if_pc, 32'h0);
    chk("rw_if_instr", bus.if_instr, memf(32'h0));

    // Address wrap at the top of the space.
    s_redir = 1'b1; s_tgt = 32'hFFFF_FFFC; cycle();
    s_redir = 1'b0; s_gnt = 1'b1; cycle();
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_next", pc_next, 32'h0);
    s_gnt = 1'b0; s_rv = 1'b1; s_rd = memf(32'hFFFF_FFFC); cycle();
    chk("wrap_pc_cur", pc_cur, 32'h0);
    s_rv = 1'b0; cycle();
    chk("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
    chk("wrap_next_addr", bus.imem_addr, 32'h0);

    // Random traffic against the in-order stream model.
    auto_mem = 1'b1; gnt_pct = 60; max_dly = 3;
    do_reset();
    ndeliv = 0;
    for (int i = 0; i < 4000; i++) begin
      s_rdy   = ($urandom_range(99) < 70);
      s_redir = ($urandom_range(99) < 4);
      s_tgt   = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cycle();
    end
    s_redir = 1'b0; s_rdy = 1'b1;
    repeat (10) cycle();
    chk("random_progress", {31'h0, ndeliv > 200}, 32'h1);

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
